// File: rtl/wb_bram_burst.sv
// Wishbone B4 classic slave block RAM with registered incrementing/wrapping
// bursts, byte-lane writes and out-of-range error termination.
module wb_bram_burst #(
    parameter int MEM_ADR_WIDTH = 11,
    parameter int DATA_WIDTH    = 32,
    parameter int BUS_ADR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cyc,
    input  logic                     stb,
    input  logic                     we,
    input  logic [BUS_ADR_WIDTH-1:0] adr,
    input  logic [DATA_WIDTH/8-1:0]  sel,
    input  logic [DATA_WIDTH-1:0]    dat_ms,
    input  logic [2:0]               cti,
    input  logic [1:0]               bte,
    output logic [DATA_WIDTH-1:0]    dat_sm,
    output logic                     ack,
    output logic                     err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LB    = $clog2(NB);
    localparam int AW    = MEM_ADR_WIDTH + LB;
    localparam int DEPTH = 2 ** MEM_ADR_WIDTH;

    localparam logic [2:0] CTI_INC = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SINGLE,
        S_BURST,
        S_ERR
    } state_t;

    state_t                   state_q, state_d;
    logic                     ack_q, ack_d;
    logic                     err_q, err_d;
    logic [MEM_ADR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0]    dat_q;
    logic                     dat_en;

    logic [DATA_WIDTH-1:0]    mem [0:DEPTH-1];

    logic                     req;
    logic                     oor;
    logic                     wr;
    logic [MEM_ADR_WIDTH-1:0] widx;
    logic [MEM_ADR_WIDTH-1:0] inc;
    logic [MEM_ADR_WIDTH-1:0] wmask;
    logic [MEM_ADR_WIDTH-1:0] nxt;
    logic                     unused_ok;

    assign req  = cyc & stb;
    assign widx = adr[AW-1:LB];
    // Any address bit above the memory window flags an out-of-range access.
    assign oor  = |(adr >> AW);
    // Writes happen on acked beats only; error beats and reset never write.
    assign wr   = req & ack_q & we & ~rst;

    // Low byte-offset bits never select anything inside a word.
    assign unused_ok = &{1'b0, adr};

    assign ack    = ack_q & cyc & stb;
    assign err    = err_q & cyc & stb;
    assign dat_sm = dat_q;

    // Next burst word: linear wraps the whole memory, wrap-N keeps upper bits.
    always_comb begin
        inc = raddr_q + MEM_ADR_WIDTH'(1);
        case (bte)
            2'b01:   wmask = MEM_ADR_WIDTH'(3);
            2'b10:   wmask = MEM_ADR_WIDTH'(7);
            2'b11:   wmask = MEM_ADR_WIDTH'(15);
            default: wmask = '1;
        endcase
        nxt = (raddr_q & ~wmask) | (inc & wmask);
    end

    // Next-state, feedback acks and read-address selection.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        raddr_d = raddr_q;
        dat_en  = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (oor) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        dat_en  = 1'b0;
                    end else begin
                        raddr_d = widx;
                        ack_d   = 1'b1;
                        state_d = (cti == CTI_INC) ? S_BURST : S_SINGLE;
                    end
                end
            end
            S_SINGLE: state_d = S_IDLE;
            S_BURST: begin
                if (req && cti == CTI_INC) begin
                    // Beat in progress: prefetch the following word.
                    ack_d   = 1'b1;
                    raddr_d = nxt;
                end else begin
                    // End-of-burst beat, other cycle type, or master stall.
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
                dat_en  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        if (!cyc) begin
            state_d = S_IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
        end
    end

    // Control registers and registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            raddr_q <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            raddr_q <= raddr_d;
            if (dat_en) dat_q <= mem[raddr_d];
        end
    end

    // Byte-lane write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            for (int i = 0; i < NB; i++) begin
                if (sel[i]) mem[widx][8*i +: 8] <= dat_ms[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed bench for wb_bram_burst: classic, burst, wrap, error, stall, reset.
module tb_wb_bram_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_sm;
    logic        ack, err;

    int checks   = 0;
    int failures = 0;

    wb_bram_burst #(.MEM_ADR_WIDTH(11), .DATA_WIDTH(32), .BUS_ADR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
        .sel(sel), .dat_ms(dat_ms), .cti(cti), .bte(bte),
        .dat_sm(dat_sm), .ack(ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
    endtask

    task automatic wr_single(input string tag, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b000; adr = a; dat_ms = d; sel = s;
        @(posedge clk); #1;
        chk({tag, "_ack"}, 32'(ack), 32'd1);
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic rd_single(input string tag, input logic [31:0] a, input logic [31:0] e);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b000; adr = a;
        @(posedge clk); #1;
        chk({tag, "_ack"}, 32'(ack), 32'd1);
        chk({tag, "_dat"}, dat_sm, e);
        @(posedge clk); #1;
        idle_bus();
    endtask

    // Burst read; w[] holds the word index of each beat (preload makes data == index).
    task automatic burst_rd(input string tag, input logic [1:0] b, input int n,
                            input int unsigned w[4]);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b010; bte = b; adr = 32'(w[0] * 4);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            adr = 32'(w[k] * 4);
            cti = (k == n - 1) ? 3'b111 : 3'b010;
            #1;
            chk($sformatf("%s_ack%0d", tag, k), 32'(ack), 32'd1);
            chk($sformatf("%s_dat%0d", tag, k), dat_sm, 32'(w[k]));
        end
        @(posedge clk); #1;
        cti = 3'b000;
        #1;
        chk({tag, "_ack_end"}, 32'(ack), 32'd0);
        idle_bus();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        adr = '0; sel = 4'hF; dat_ms = '0;
        rst = 1'b1;
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dat", dat_sm, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Byte-lane merge on word 4.
        wr_single("wr_full", 32'h10, 32'h12345678, 4'b1111);
        wr_single("wr_lane1", 32'h10, 32'h0000AA00, 4'b0010);
        rd_single("rd_merge", 32'h10, 32'h1234AA78);

        // Preload word k with k, plus the last word.
        for (int k = 0; k < 8; k++) wr_single($sformatf("pre%0d", k), 32'(k * 4), 32'(k), 4'hF);
        wr_single("pre_last", 32'h1FFC, 32'd2047, 4'hF);

        burst_rd("lin", 2'b00, 4, '{2, 3, 4, 5});
        burst_rd("wrap4", 2'b01, 4, '{6, 7, 4, 5});
        burst_rd("lin_top", 2'b00, 2, '{2047, 0, 0, 0});

        // Out-of-range write: err one cycle, no ack, data held, no write.
        rd_single("rd_w5", 32'h14, 32'd5);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b000; adr = 32'h2000;
        dat_ms = 32'hFFFFFFFF; sel = 4'hF;
        @(posedge clk); #1;
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_ack", 32'(ack), 32'd0);
        chk("oor_dat_hold", dat_sm, 32'd5);
        @(posedge clk); #1;
        chk("oor_err_clr", 32'(err), 32'd0);
        idle_bus();
        rd_single("oor_rdback", 32'h0, 32'd0);

        // Burst with a two-cycle strobe stall after beat 2.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b010; bte = 2'b00; adr = 32'h8;
        @(posedge clk); #1; #1;
        chk("stall_ack0", 32'(ack), 32'd1);
        chk("stall_dat0", dat_sm, 32'd2);
        @(posedge clk); #1; adr = 32'hC; #1;
        chk("stall_ack1", 32'(ack), 32'd1);
        chk("stall_dat1", dat_sm, 32'd3);
        @(posedge clk); #1; stb = 1'b0; #1;
        chk("stall_gap0", 32'(ack), 32'd0);
        @(posedge clk); #1; #1;
        chk("stall_gap1", 32'(ack), 32'd0);
        @(posedge clk); #1; stb = 1'b1; adr = 32'h10; #1;
        chk("stall_wait", 32'(ack), 32'd0);
        @(posedge clk); #1; #1;
        chk("stall_ack2", 32'(ack), 32'd1);
        chk("stall_dat2", dat_sm, 32'd4);
        @(posedge clk); #1; adr = 32'h14; cti = 3'b111; #1;
        chk("stall_ack3", 32'(ack), 32'd1);
        chk("stall_dat3", dat_sm, 32'd5);
        @(posedge clk); #1; cti = 3'b000; #1;
        chk("stall_end", 32'(ack), 32'd0);
        idle_bus();
        @(posedge clk); #1;

        // Reset in the middle of a write burst: outputs clear, second beat not written.
        cyc = 1'b1; stb = 1'b1; we = 1'b1; cti = 3'b010; bte = 2'b00;
        adr = 32'h18; dat_ms = 32'hA5A5A5A5; sel = 4'hF;
        @(posedge clk); #1;
        chk("rb_ack0", 32'(ack), 32'd1);
        @(posedge clk); #1;
        adr = 32'h1C; dat_ms = 32'h5A5A5A5A;
        #1 rst = 1'b1;
        #1;
        chk("rb_ack", 32'(ack), 32'd0);
        chk("rb_err", 32'(err), 32'd0);
        chk("rb_dat", dat_sm, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_bus();
        @(posedge clk); #1;
        rd_single("rb_w7", 32'h1C, 32'd7);
        rd_single("rb_w6", 32'h18, 32'hA5A5A5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
